// File: rtl/dpram_bist_ctrl.sv
// dpram_bist_ctrl
// Built-in self-test initiator for a true dual-port RAM (synchronous write,
// registered read). A start pulse runs a four-phase march:
//   write ascending on port A, read ascending on port B,
//   write inverted data descending on port B, read descending on port A.
// Every read word is compared in hardware and the run reports pass/fail,
// a saturating error count and the first failing location/port.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle run request (accepted in IDLE/DONE only)
//   busy, done           run in progress / run complete (held until next start)
//   fail, err_count      sticky mismatch flag, saturating mismatch count
//   fail_addr, fail_port address and port (0 = A, 1 = B) of first mismatch
//   data_a/addr_a/we_a   RAM port A drive, q_a port A read data
//   data_b/addr_b/we_b   RAM port B drive, q_b port B read data
//
// state | meaning
// IDLE  | waiting for start, all drives quiet
// W_A   | port A writes D(k), k = 0..DEPTH-1
// R_B   | port B reads k = 0..DEPTH-1, plus one cycle to drain the last compare
// W_B   | port B writes ~D(k), k = DEPTH-1..0
// R_A   | port A reads k = DEPTH-1..0, plus one cycle to drain the last compare
// DONE  | run finished, results held, waiting for start
module dpram_bist_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55,
  parameter int                    ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_port,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  we_a,
  input  logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] q_b
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W_A  = 3'd1,
    R_B  = 3'd2,
    W_B  = 3'd3,
    R_A  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  // rd_iss marks a cycle in which a read address is on the RAM port;
  // the pend_* stage holds that address/expected word until q is valid.
  logic                    rd_iss;
  logic                    rd_port;
  logic                    pend_vld;
  logic                    pend_port;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [DATA_WIDTH-1:0]   pend_exp;
  logic [DATA_WIDTH-1:0]   q_sel;
  logic                    mismatch;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] k);
    return PATTERN ^ DATA_WIDTH'(k);
  endfunction

  assign q_sel    = pend_port ? q_b : q_a;
  assign mismatch = pend_vld && (q_sel != pend_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_iss    <= 1'b0;
      rd_port   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_port <= 1'b0;
      pend_addr <= '0;
      pend_exp  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
      data_a    <= '0;
      addr_a    <= '0;
      we_a      <= 1'b0;
      data_b    <= '0;
      addr_b    <= '0;
      we_b      <= 1'b0;
    end else begin
      // Compare pipeline: address issued in cycle c, q valid in c+1.
      pend_vld  <= rd_iss;
      pend_port <= rd_port;
      pend_addr <= rd_port ? addr_b : addr_a;
      pend_exp  <= rd_port ? pat(addr_b) : ~pat(addr_a);

      if (mismatch) begin
        fail <= 1'b1;
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (!fail) begin
          fail_addr <= pend_addr;
          fail_port <= pend_port;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= W_A;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            cnt       <= '0;
            we_a      <= 1'b1;
            addr_a    <= '0;
            data_a    <= pat('0);
          end
        end

        W_A: begin
          if (cnt == ADDR_MAX) begin
            state   <= R_B;
            cnt     <= '0;
            we_a    <= 1'b0;
            addr_a  <= '0;
            data_a  <= '0;
            addr_b  <= '0;
            rd_iss  <= 1'b1;
            rd_port <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            addr_a <= cnt + 1'b1;
            data_a <= pat(cnt + 1'b1);
          end
        end

        R_B: begin
          if (rd_iss) begin
            if (cnt == ADDR_MAX) begin
              rd_iss <= 1'b0;
              addr_b <= '0;
            end else begin
              cnt    <= cnt + 1'b1;
              addr_b <= cnt + 1'b1;
            end
          end else begin
            // drain cycle done; start descending inverted writes on B
            state  <= W_B;
            cnt    <= ADDR_MAX;
            we_b   <= 1'b1;
            addr_b <= ADDR_MAX;
            data_b <= ~pat(ADDR_MAX);
          end
        end

        W_B: begin
          if (cnt == '0) begin
            state   <= R_A;
            cnt     <= ADDR_MAX;
            we_b    <= 1'b0;
            addr_b  <= '0;
            data_b  <= '0;
            addr_a  <= ADDR_MAX;
            rd_iss  <= 1'b1;
            rd_port <= 1'b0;
          end else begin
            cnt    <= cnt - 1'b1;
            addr_b <= cnt - 1'b1;
            data_b <= ~pat(cnt - 1'b1);
          end
        end

        R_A: begin
          if (rd_iss) begin
            if (cnt == '0) begin
              rd_iss <= 1'b0;
              addr_a <= '0;
            end else begin
              cnt    <= cnt - 1'b1;
              addr_a <= cnt - 1'b1;
            end
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
module tb_dpram_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, fail, fail_port;
  logic [7:0] err_count;
  logic [5:0] fail_addr;
  logic [7:0] data_a, data_b, q_a, q_b;
  logic [5:0] addr_a, addr_b;
  logic       we_a, we_b;

  // second instance: 4-bit error counter against an all-zero-reading RAM
  logic       start2;
  logic       busy2, done2, fail2, fail_port2;
  logic [3:0] err_count2;
  logic [5:0] fail_addr2;
  logic [7:0] data_a2, data_b2;
  logic [5:0] addr_a2, addr_b2;
  logic       we_a2, we_b2;
  logic [7:0] zero8;

  int fault;  // 0 none, 1 port-B addr16 bit3 stuck-1, 2 addr bit5 ignored
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       busy;
    logic       we_a;
    logic [5:0] addr_a;
    logic [7:0] data_a;
    logic       we_b;
    logic [5:0] addr_b;
    logic [7:0] data_b;
  } drv_t;

  typedef struct packed {
    logic       fail;
    logic [7:0] err;
    logic [5:0] faddr;
    logic       fport;
  } res_t;

  drv_t drv_q[$];
  res_t res_q[$];

  dpram_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .fail(fail), .err_count(err_count),
    .fail_addr(fail_addr), .fail_port(fail_port),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .q_b(q_b)
  );

  dpram_bist_ctrl #(.ERR_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .done(done2), .fail(fail2), .err_count(err_count2),
    .fail_addr(fail_addr2), .fail_port(fail_port2),
    .data_a(data_a2), .addr_a(addr_a2), .we_a(we_a2), .q_a(zero8),
    .data_b(data_b2), .addr_b(addr_b2), .we_b(we_b2), .q_b(zero8)
  );

  assign zero8 = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural dual-port RAM with injectable faults
  logic [7:0] mem [64];

  function automatic int ridx(input logic [5:0] a, input int f);
    return (f == 2) ? int'(a & 6'h1f) : int'(a);
  endfunction

  always @(posedge clk) begin
    if (we_a) mem[ridx(addr_a, fault)] <= data_a;
    if (we_b) mem[ridx(addr_b, fault)] <= data_b;
    q_a <= mem[ridx(addr_a, fault)];
    q_b <= mem[ridx(addr_b, fault)] | ((fault == 1 && addr_b == 6'd16) ? 8'h08 : 8'h00);
  end

  function automatic logic [7:0] pat(input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return 8'h55 ^ kk;
  endfunction

  function automatic drv_t exp_drive(input int i);
    drv_t d;
    int   j;
    d = '0;
    d.busy = 1'b1;
    if (i < 64) begin
      d.we_a = 1'b1; d.addr_a = 6'(i); d.data_a = pat(i);
    end else if (i < 129) begin
      j = i - 64;
      d.addr_b = (j < 64) ? 6'(j) : 6'd0;
    end else if (i < 193) begin
      j = i - 129;
      d.we_b = 1'b1; d.addr_b = 6'(63 - j); d.data_b = ~pat(63 - j);
    end else begin
      j = i - 193;
      d.addr_a = (j < 64) ? 6'(63 - j) : 6'd0;
    end
    return d;
  endfunction

  // Abstract march against a faulty RAM: f 0..2 as above, 3 = reads return 0.
  function automatic res_t model_run(input int f, input int emax);
    logic [7:0] m [64];
    logic [7:0] r;
    res_t       res;
    int         cnt;
    res = '0;
    cnt = 0;
    for (int k = 0; k < 64; k++) m[ridx(6'(k), f)] = pat(k);
    for (int k = 0; k < 64; k++) begin
      r = m[ridx(6'(k), f)];
      if (f == 1 && k == 16) r = r | 8'h08;
      if (f == 3) r = 8'h00;
      if (r != pat(k)) begin
        if (!res.fail) begin res.faddr = 6'(k); res.fport = 1'b1; end
        res.fail = 1'b1;
        if (cnt < emax) cnt++;
      end
    end
    for (int k = 63; k >= 0; k--) m[ridx(6'(k), f)] = ~pat(k);
    for (int k = 63; k >= 0; k--) begin
      r = m[ridx(6'(k), f)];
      if (f == 3) r = 8'h00;
      if (r != ~pat(k)) begin
        if (!res.fail) begin res.faddr = 6'(k); res.fport = 1'b0; end
        res.fail = 1'b1;
        if (cnt < emax) cnt++;
      end
    end
    res.err = 8'(cnt);
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] all_out();
    return {busy, done, fail, err_count, fail_addr, fail_port,
            data_a, addr_a, we_a, data_b, addr_b, we_b};
  endfunction

  // One run: fault select, cycle at which a start is re-pulsed (ignored),
  // cycle at which reset is asserted (abandon), and whether to spot-check q.
  task automatic run(input int f, input int restart_at, input int abort_at, input bit check_q);
    drv_t d;
    res_t r;
    drv_t cur;
    fault = f;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 258; i++) drv_q.push_back(exp_drive(i));
    res_q.push_back(model_run(f, 255));
    @(negedge clk);
    start = 1'b0;
    chk("start_clr_done", 64'(done), 64'(1'b0));
    chk("start_clr_fail", 64'(fail), 64'(1'b0));
    chk("start_clr_err", 64'(err_count), 64'(8'd0));
    for (int i = 0; i < 258; i++) begin
      start = (i == restart_at);
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(all_out()), 64'(48'd0));
        drv_q.delete();
        res_q.delete();
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("held_reset_outputs", 64'(all_out()), 64'(48'd0));
        rst_n = 1'b1;
        return;
      end
      d   = drv_q.pop_front();
      cur = '{busy, we_a, addr_a, data_a, we_b, addr_b, data_b};
      chk($sformatf("drive_c%0d", i), 64'(cur), 64'(d));
      if (check_q && i == 81)  chk("q_b_addr16", 64'(q_b), 64'(8'h45));
      if (check_q && i == 241) chk("q_a_addr16", 64'(q_a), 64'(8'hBA));
      @(negedge clk);
    end
    start = 1'b0;
    chk("end_busy", 64'(busy), 64'(1'b0));
    chk("end_done", 64'(done), 64'(1'b1));
    r = res_q.pop_front();
    chk($sformatf("result_fault%0d", f),
        64'({fail, err_count, fail_addr, fail_port}), 64'(r));
  endtask

  initial begin
    res_t r2;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    fault  = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(all_out()), 64'(48'd0));
    chk("reset_busy2", 64'({busy2, done2, fail2}), 64'(3'd0));
    rst_n = 1'b1;
    @(negedge clk);

    run(0, -1, -1, 1'b1);   // fault-free pass
    run(1, -1, -1, 1'b0);   // port B addr 16 bit 3 stuck: 1 error
    run(0, 50, -1, 1'b0);   // restart from DONE, stray start mid-run ignored
    run(2, -1, -1, 1'b0);   // address alias: 64 errors
    run(0, -1, 100, 1'b0);  // reset mid-run
    run(0, -1, -1, 1'b0);   // clean rerun after reset

    // saturating 4-bit counter
    @(negedge clk);
    start2 = 1'b1;
    res_q.push_back(model_run(3, 15));
    @(negedge clk);
    start2 = 1'b0;
    chk("sat_busy_first", 64'(busy2), 64'(1'b1));
    repeat (257) @(negedge clk);
    chk("sat_busy_last", 64'(busy2), 64'(1'b1));
    @(negedge clk);
    chk("sat_done", 64'({busy2, done2}), 64'(2'b01));
    r2 = res_q.pop_front();
    chk("sat_result", 64'({fail2, 4'd0, err_count2, fail_addr2, fail_port2}), 64'(r2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
